// File: rtl/uart_tx.sv
// UART transmitter (8N1): valid/ready FIFO in front of a frame FSM and shift datapath.
// Optional even-parity bit between data and stop when UART_TX_PARITY_EN is defined.

module uart_tx_ctrl (
  input  logic i_SysClock,
  input  logic i_ResetN,
  input  logic fifo_empty,
  input  logic baud_end,
  input  logic baud_pre_end,
  input  logic bit_last,
  output logic pop,
  output logic shift_en,
  output logic bit_inc,
  output logic drv_stop,
`ifdef UART_TX_PARITY_EN
  output logic drv_par,
`endif
  output logic busy,
  output logic done
);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif
  state_t state;

  // Datapath strobes; a pop always starts a frame (line low, counters cleared)
  always_comb begin
    pop      = 1'b0;
    shift_en = 1'b0;
    bit_inc  = 1'b0;
    drv_stop = 1'b0;
`ifdef UART_TX_PARITY_EN
    drv_par  = 1'b0;
`endif
    case (state)
      S_IDLE:  pop = !fifo_empty;
      S_START: shift_en = baud_end;
      S_DATA:
        if (baud_end) begin
          if (bit_last) begin
`ifdef UART_TX_PARITY_EN
            drv_par = 1'b1;
`else
            drv_stop = 1'b1;
`endif
          end else begin
            shift_en = 1'b1;
            bit_inc  = 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
      S_PARITY: drv_stop = baud_end;
`endif
      S_STOP:  pop = baud_end && !fifo_empty;
      default: ;
    endcase
  end

  always_ff @(posedge i_SysClock or negedge i_ResetN) begin
    if (!i_ResetN) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE:
          if (!fifo_empty) begin
            state <= S_START;
            busy  <= 1'b1;
          end
        S_START: if (baud_end) state <= S_DATA;
        S_DATA:
          if (baud_end && bit_last) begin
`ifdef UART_TX_PARITY_EN
            state <= S_PARITY;
`else
            state <= S_STOP;
`endif
          end
`ifdef UART_TX_PARITY_EN
        S_PARITY: if (baud_end) state <= S_STOP;
`endif
        S_STOP: begin
          // look-ahead so the registered pulse lands on the last stop clock
          done <= baud_pre_end;
          if (baud_end) begin
            if (fifo_empty) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= S_START;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

module uart_tx_dp #(
  parameter int MAX_CYCLE_CNT = 433,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          i_SysClock,
  input  logic                          i_ResetN,
  input  logic [7:0]                    tx_byte,
  input  logic                          tx_valid,
  input  logic                          pop,
  input  logic                          shift_en,
  input  logic                          bit_inc,
  input  logic                          drv_stop,
`ifdef UART_TX_PARITY_EN
  input  logic                          drv_par,
`endif
  input  logic                          run,
  output logic                          tx_ready,
  output logic                          tx_serial,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fifo_empty,
  output logic                          baud_end,
  output logic                          baud_pre_end,
  output logic                          bit_last
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = (MAX_CYCLE_CNT > 0) ? $clog2(MAX_CYCLE_CNT + 1) : 1;

  logic [FIFO_DEPTH-1:0][7:0] mem;
  logic [PTR_W-1:0]           wr_ptr, rd_ptr;
  logic [CNT_W-1:0]           baud_cnt;
  logic [2:0]                 bit_cnt;
  logic [7:0]                 shift;
  logic                       push;
`ifdef UART_TX_PARITY_EN
  logic                       par;
`endif

  assign tx_ready     = fifo_count != (PTR_W+1)'(FIFO_DEPTH);
  assign push         = tx_valid && tx_ready;
  assign fifo_empty   = fifo_count == '0;
  assign baud_end     = baud_cnt == CNT_W'(MAX_CYCLE_CNT);
  assign baud_pre_end = baud_cnt == CNT_W'(MAX_CYCLE_CNT - 1);
  assign bit_last     = bit_cnt == 3'd7;

  always_ff @(posedge i_SysClock)
    if (push) mem[wr_ptr] <= tx_byte;

  // Pointers wrap for free since depth is a power of two
  always_ff @(posedge i_SysClock or negedge i_ResetN) begin
    if (!i_ResetN) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (PTR_W+1)'(1);
        2'b01:   fifo_count <= fifo_count - (PTR_W+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_SysClock or negedge i_ResetN) begin
    if (!i_ResetN) begin
      tx_serial <= 1'b1;
      shift     <= '0;
      bit_cnt   <= '0;
      baud_cnt  <= '0;
`ifdef UART_TX_PARITY_EN
      par       <= 1'b0;
`endif
    end else if (pop) begin
      tx_serial <= 1'b0;
      shift     <= mem[rd_ptr];
      bit_cnt   <= '0;
      baud_cnt  <= '0;
`ifdef UART_TX_PARITY_EN
      par       <= ^mem[rd_ptr];
`endif
    end else begin
      baud_cnt <= (!run || baud_end) ? '0 : baud_cnt + CNT_W'(1);
      if (shift_en) begin
        tx_serial <= shift[0];
        shift     <= {1'b0, shift[7:1]};
      end
      if (bit_inc)  bit_cnt   <= bit_cnt + 3'd1;
`ifdef UART_TX_PARITY_EN
      if (drv_par)  tx_serial <= par;
`endif
      if (drv_stop) tx_serial <= 1'b1;
    end
  end
endmodule

module uart_tx #(
  parameter int SYS_CLOCK     = 50000000,
  parameter int UART_BAUDRATE = 115200,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                        i_SysClock,
  input  logic                        i_ResetN,
  input  logic [7:0]                  i_TxByte,
  input  logic                        i_TxValid,
  output logic                        o_TxReady,
  output logic                        o_TxSerial,
  output logic                        o_TxBusy,
  output logic                        o_TxDone,
  output logic [$clog2(FIFO_DEPTH):0] o_FifoCount
);
  localparam int MAX_CYCLE_CNT = ((SYS_CLOCK * 10 / UART_BAUDRATE + 5) / 10) - 1;

  logic pop, shift_en, bit_inc, drv_stop;
  logic fifo_empty, baud_end, baud_pre_end, bit_last;
`ifdef UART_TX_PARITY_EN
  logic drv_par;
`endif

  uart_tx_ctrl u_ctrl (
    .i_SysClock   (i_SysClock),
    .i_ResetN     (i_ResetN),
    .fifo_empty   (fifo_empty),
    .baud_end     (baud_end),
    .baud_pre_end (baud_pre_end),
    .bit_last     (bit_last),
    .pop          (pop),
    .shift_en     (shift_en),
    .bit_inc      (bit_inc),
    .drv_stop     (drv_stop),
`ifdef UART_TX_PARITY_EN
    .drv_par      (drv_par),
`endif
    .busy         (o_TxBusy),
    .done         (o_TxDone)
  );

  uart_tx_dp #(
    .MAX_CYCLE_CNT (MAX_CYCLE_CNT),
    .FIFO_DEPTH    (FIFO_DEPTH)
  ) u_dp (
    .i_SysClock   (i_SysClock),
    .i_ResetN     (i_ResetN),
    .tx_byte      (i_TxByte),
    .tx_valid     (i_TxValid),
    .pop          (pop),
    .shift_en     (shift_en),
    .bit_inc      (bit_inc),
    .drv_stop     (drv_stop),
`ifdef UART_TX_PARITY_EN
    .drv_par      (drv_par),
`endif
    .run          (o_TxBusy),
    .tx_ready     (o_TxReady),
    .tx_serial    (o_TxSerial),
    .fifo_count   (o_FifoCount),
    .fifo_empty   (fifo_empty),
    .baud_end     (baud_end),
    .baud_pre_end (baud_pre_end),
    .bit_last     (bit_last)
  );
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: scoreboarded line monitor at 10 clk/bit, plus a default-rate instance.
module tb_uart_tx;
  localparam int BIT   = 10;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
  localparam int LAST_RUN = 868;
`else
  localparam int NB = 10;
  localparam int LAST_RUN = 434;
`endif
  localparam int FRAME = NB * BIT;

  logic clk = 1'b0, rst_n = 1'b1;
  logic valid = 1'b0, ready, serial, busy, done;
  logic [7:0] byte_in = '0;
  logic [CW-1:0] count;
  logic d_valid = 1'b0, d_ready, d_serial, d_busy, d_done;
  logic [7:0] d_byte = '0;
  logic [CW-1:0] d_count;

  uart_tx #(.SYS_CLOCK(1000000), .UART_BAUDRATE(100000), .FIFO_DEPTH(DEPTH)) dut (
    .i_SysClock(clk), .i_ResetN(rst_n), .i_TxByte(byte_in), .i_TxValid(valid),
    .o_TxReady(ready), .o_TxSerial(serial), .o_TxBusy(busy), .o_TxDone(done),
    .o_FifoCount(count));

  uart_tx dut_def (
    .i_SysClock(clk), .i_ResetN(rst_n), .i_TxByte(d_byte), .i_TxValid(d_valid),
    .o_TxReady(d_ready), .o_TxSerial(d_serial), .o_TxBusy(d_busy), .o_TxDone(d_done),
    .o_FifoCount(d_count));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] data; logic [9:0] line; logic par; } vec_t;
  typedef struct { logic [9:0] line; logic par; } exp_t;
  exp_t sb[$];
  int frame_start[$];
  int checks = 0, fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] b);
    return '{line: {1'b1, b, 1'b0}, par: ^b};
  endfunction

  task automatic send(input logic [7:0] b, input exp_t e);
    int n = 0;
    valid = 1'b1; byte_in = b;
    while (!ready && n < 1000) begin @(negedge clk); n++; end
    if (!ready) begin
      checks++; fails++;
      $display("FAIL send_timeout: ready stuck at %0b expected 1", ready);
    end else begin
      @(posedge clk);
      sb.push_back(e);
    end
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while ((sb.size() != 0 || busy !== 1'b0) && n < maxc) begin @(negedge clk); n++; end
    chk("drain", {30'b0, sb.size() != 0, busy}, 32'd0);
    chk("line_idle", {31'b0, serial}, 32'd1);
  endtask

  // Line monitor: captures each whole frame, checks bit stability and done position, pops scoreboard
  initial begin : monitor
    logic [FRAME-1:0] s, d;
    logic [NB-1:0] got, expf;
    int unstable, bad, st;
    bit abort;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n || serial !== 1'b0) continue;
      abort = 1'b0; st = cyc;
      for (int k = 0; k < FRAME; k++) begin
        if (k > 0) @(negedge clk);
        if (!rst_n) begin abort = 1'b1; break; end
        s[k] = serial; d[k] = done;
      end
      if (abort) continue;
      frame_start.push_back(st);
      unstable = 0; bad = 0;
      for (int j = 0; j < NB; j++) begin
        got[j] = s[j*BIT];
        for (int i = 0; i < BIT; i++) if (s[j*BIT+i] !== got[j]) unstable++;
      end
      for (int k = 0; k < FRAME; k++) if (d[k] !== (k == FRAME-1)) bad++;
      chk("bit_stable", unstable, 0);
      chk("done_pulse", bad, 0);
      if (sb.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_frame: got frame %b expected none", got);
      end else begin
        e = sb.pop_front();
`ifdef UART_TX_PARITY_EN
        expf = {1'b1, e.par, e.line[8:0]};
`else
        expf = e.line;
`endif
        chk("frame", 32'(got), 32'(expf));
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    vec_t tbl[7];
    int n, bad, base;
    logic lvl;
    tbl[0] = '{8'hA5, 10'b1_10100101_0, 1'b0};
    tbl[1] = '{8'h00, 10'b1_00000000_0, 1'b0};
    tbl[2] = '{8'hFF, 10'b1_11111111_0, 1'b0};
    tbl[3] = '{8'h07, 10'b1_00000111_0, 1'b1};
    tbl[4] = '{8'h03, 10'b1_00000011_0, 1'b0};
    tbl[5] = '{8'h3C, 10'b1_00111100_0, 1'b0};
    tbl[6] = '{8'h80, 10'b1_10000000_0, 1'b1};

    // asynchronous reset before any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("rst_serial", {31'b0, serial}, 32'd1);
    chk("rst_busy",   {31'b0, busy},   32'd0);
    chk("rst_done",   {31'b0, done},   32'd0);
    chk("rst_ready",  {31'b0, ready},  32'd1);
    chk("rst_count",  32'(count),      32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      send(tbl[i].data, '{line: tbl[i].line, par: tbl[i].par});
      drain(2 * FRAME + 20);
    end

    // back-to-back frames: no idle gap
    base = frame_start.size();
    send(8'h00, mk(8'h00));
    send(8'hFF, mk(8'hFF));
    drain(3 * FRAME);
    if (frame_start.size() >= base + 2)
      chk("b2b_gap", frame_start[base+1] - frame_start[base], FRAME);
    else begin
      checks++; fails++;
      $display("FAIL b2b_frames: got %0d frames expected 2", frame_start.size() - base);
    end

    // hold valid with 0x01..0x06: FIFO fills, 0x06 waits for the first frame to end
    valid = 1'b1;
    for (int b = 1; b <= 5; b++) begin
      byte_in = 8'(b);
      chk("fill_ready", {31'b0, ready}, 32'd1);
      @(posedge clk);
      sb.push_back(mk(8'(b)));
      @(negedge clk);
    end
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_full",  {31'b0, ready}, 32'd0);
    byte_in = 8'h06; n = 0; bad = 0;
    while (done !== 1'b1 && n < FRAME + 20) begin
      if (ready !== 1'b0 || count !== CW'(4)) bad++;
      @(negedge clk); n++;
    end
    chk("full_refuse", bad, 0);
    chk("full_done_seen", {31'b0, done}, 32'd1);
    @(negedge clk);
    chk("full_pushpop_count", 32'(count), 32'd3);
    chk("full_pushpop_ready", {31'b0, ready}, 32'd1);
    @(posedge clk);
    sb.push_back(mk(8'h06));
    @(negedge clk);
    valid = 1'b0;
    chk("refill_count", 32'(count), 32'd4);
    drain(7 * FRAME);

    // default rate: every bit exactly 434 clocks (0x55 toggles on each bit)
    chk("def_ready", {31'b0, d_ready}, 32'd1);
    d_valid = 1'b1; d_byte = 8'h55;
    @(posedge clk);
    @(negedge clk);
    d_valid = 1'b0;
    n = 0;
    while (d_serial !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    chk("def_start", {31'b0, d_serial}, 32'd0);
    lvl = 1'b0;
    for (int r = 0; r < 9; r++) begin
      n = 0;
      while (d_serial === lvl && n < 2000) begin n++; @(negedge clk); end
      chk($sformatf("def_bit_period_%0d", r), n, (r == 8) ? LAST_RUN : 434);
      lvl = ~lvl;
    end
    n = 1;
    while (d_done !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    chk("def_stop_period", n, 434);
    @(negedge clk);
    chk("def_busy_after", {31'b0, d_busy}, 32'd0);
    chk("def_count", 32'(d_count), 32'd0);

    // reset during data bit 3 with two bytes queued
    send(8'h00, mk(8'h00));
    send(8'h00, mk(8'h00));
    send(8'h00, mk(8'h00));
    repeat (44) @(negedge clk);
    chk("pre_rst_count",  32'(count), 32'd2);
    chk("pre_rst_serial", {31'b0, serial}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_serial", {31'b0, serial}, 32'd1);
    chk("mid_rst_count",  32'(count), 32'd0);
    chk("mid_rst_ready",  {31'b0, ready}, 32'd1);
    chk("mid_rst_busy",   {31'b0, busy}, 32'd0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (serial !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("post_rst_idle", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
